// File: rtl/sr_flag_bank.sv
// sr_flag_bank
//   A bank of independent set/reset flags shared between producer and consumer
//   state machines, for example frame-ready or buffer-swap handshakes. Each
//   flag supports:
//     - a configurable rule for a simultaneous set and clear;
//     - an optional edge-qualified set;
//     - an optional auto-clear after a fixed high time, restarted by a new set.
//   Registered rise, fall and timeout pulses are produced per flag, together
//   with aggregate status.
//
// Parameters
//   N_FLAGS        number of flags (1..32)
//   CONFLICT_MODE  set and clear in the same cycle:
//                  0 = hold, 1 = set wins, 2 = clear wins, 3 = toggle
//   EDGE_SET       1 = a flag sets only on a 0->1 transition of its set bit
//   TIMEOUT_CYCLES 0 = no auto-clear; otherwise the flag's high time in cycles
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   set_i      per-flag set request
//   rst_i      per-flag clear request
//   state_o    registered flag values
//   rise_o     one-cycle pulse in the first cycle a flag reads 1
//   fall_o     one-cycle pulse in the first cycle a flag reads 0 after 1
//   timeout_o  one-cycle pulse together with fall_o when the auto-clear fired
//   any_o      OR of state_o
//   all_o      AND of state_o
//   count_o    number of flags that are high, registered with state_o
module sr_flag_bank #(
   parameter int N_FLAGS        = 4,
   parameter int CONFLICT_MODE  = 3,
   parameter int EDGE_SET       = 0,
   parameter int TIMEOUT_CYCLES = 0,
   localparam int CNT_W         = $clog2(N_FLAGS + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_FLAGS-1:0] set_i,
   input  logic [N_FLAGS-1:0] rst_i,
   output logic [N_FLAGS-1:0] state_o,
   output logic [N_FLAGS-1:0] rise_o,
   output logic [N_FLAGS-1:0] fall_o,
   output logic [N_FLAGS-1:0] timeout_o,
   output logic               any_o,
   output logic               all_o,
   output logic [CNT_W-1:0]   count_o
);

   logic [N_FLAGS-1:0] s_eff;
   logic [N_FLAGS-1:0] q_res;
   logic [N_FLAGS-1:0] expire;
   logic [N_FLAGS-1:0] q_next;
   logic [CNT_W-1:0]   cnt_next;

   // The set history is cleared by reset. A set that is held through the
   // release of reset therefore counts as an edge in the first cycle.
   generate
      if (EDGE_SET != 0) begin : g_edge
         logic [N_FLAGS-1:0] set_q;

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               set_q <= '0;
            end else begin
               set_q <= set_i;
            end
         end

         assign s_eff = set_i & ~set_q;
      end else begin : g_level
         assign s_eff = set_i;
      end
   endgenerate

   always_comb begin
      q_res = state_o;
      for (int k = 0; k < N_FLAGS; k++) begin
         case ({s_eff[k], rst_i[k]})
            2'b10: q_res[k] = 1'b1;
            2'b01: q_res[k] = 1'b0;
            2'b11: begin
               case (CONFLICT_MODE)
                  0:       q_res[k] = state_o[k];
                  1:       q_res[k] = 1'b1;
                  2:       q_res[k] = 1'b0;
                  default: q_res[k] = ~state_o[k];
               endcase
            end
            default: q_res[k] = state_o[k];
         endcase
      end
   end

   // Each timer loads with the remaining high time when its flag rises or is
   // retriggered. It counts down while the flag stays high, and the auto-clear
   // fires at zero. An explicit clear leaves q_res low, so expire stays 0 and
   // the fall is attributed to the clear rather than to the timeout.
   generate
      if (TIMEOUT_CYCLES > 0) begin : g_tmo
         localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

         logic [TW-1:0] tmr [N_FLAGS];

         always_comb begin
            expire = '0;
            for (int k = 0; k < N_FLAGS; k++) begin
               expire[k] = state_o[k] & q_res[k] & (tmr[k] == '0);
            end
         end

         always_ff @(posedge clk) begin
            for (int k = 0; k < N_FLAGS; k++) begin
               if (!reset_n || !q_next[k]) begin
                  tmr[k] <= '0;
               end else if (!state_o[k] || s_eff[k]) begin
                  tmr[k] <= TMR_LOAD;
               end else begin
                  tmr[k] <= tmr[k] - 1'b1;
               end
            end
         end
      end else begin : g_no_tmo
         assign expire = '0;
      end
   endgenerate

   assign q_next = q_res & ~expire;

   always_comb begin
      cnt_next = '0;
      for (int k = 0; k < N_FLAGS; k++) begin
         cnt_next = cnt_next + CNT_W'(q_next[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_o   <= '0;
         rise_o    <= '0;
         fall_o    <= '0;
         timeout_o <= '0;
         count_o   <= '0;
      end else begin
         state_o   <= q_next;
         rise_o    <= q_next & ~state_o;
         fall_o    <= ~q_next & state_o;
         timeout_o <= expire;
         count_o   <= cnt_next;
      end
   end

   assign any_o = |state_o;
   assign all_o = &state_o;

endmodule

// File: tb/tb_sr_flag_bank.sv
module tb_sr_flag_bank;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] set_i;
   logic [3:0] rst_i;

   always #5 clk = ~clk;

   // l3: toggle mode, level set, no timeout
   logic [3:0] st_l3, ri_l3, fa_l3, to_l3;
   logic       any_l3, all_l3;
   logic [2:0] cnt_l3;
   // m0/m1/m2: hold / set-wins / clear-wins, level set, no timeout
   logic [3:0] st_m0, ri_m0, fa_m0, to_m0;
   logic       any_m0, all_m0;
   logic [2:0] cnt_m0;
   logic [3:0] st_m1, ri_m1, fa_m1, to_m1;
   logic       any_m1, all_m1;
   logic [2:0] cnt_m1;
   logic [3:0] st_m2, ri_m2, fa_m2, to_m2;
   logic       any_m2, all_m2;
   logic [2:0] cnt_m2;
   // mn: toggle mode, edge set, timeout of 4 cycles
   logic [3:0] st_mn, ri_mn, fa_mn, to_mn;
   logic       any_mn, all_mn;
   logic [2:0] cnt_mn;

   sr_flag_bank #(.N_FLAGS(4), .CONFLICT_MODE(3), .EDGE_SET(0), .TIMEOUT_CYCLES(0)) u_l3 (
      .clk(clk), .reset_n(reset_n), .set_i(set_i), .rst_i(rst_i),
      .state_o(st_l3), .rise_o(ri_l3), .fall_o(fa_l3), .timeout_o(to_l3),
      .any_o(any_l3), .all_o(all_l3), .count_o(cnt_l3));

   sr_flag_bank #(.N_FLAGS(4), .CONFLICT_MODE(0), .EDGE_SET(0), .TIMEOUT_CYCLES(0)) u_m0 (
      .clk(clk), .reset_n(reset_n), .set_i(set_i), .rst_i(rst_i),
      .state_o(st_m0), .rise_o(ri_m0), .fall_o(fa_m0), .timeout_o(to_m0),
      .any_o(any_m0), .all_o(all_m0), .count_o(cnt_m0));

   sr_flag_bank #(.N_FLAGS(4), .CONFLICT_MODE(1), .EDGE_SET(0), .TIMEOUT_CYCLES(0)) u_m1 (
      .clk(clk), .reset_n(reset_n), .set_i(set_i), .rst_i(rst_i),
      .state_o(st_m1), .rise_o(ri_m1), .fall_o(fa_m1), .timeout_o(to_m1),
      .any_o(any_m1), .all_o(all_m1), .count_o(cnt_m1));

   sr_flag_bank #(.N_FLAGS(4), .CONFLICT_MODE(2), .EDGE_SET(0), .TIMEOUT_CYCLES(0)) u_m2 (
      .clk(clk), .reset_n(reset_n), .set_i(set_i), .rst_i(rst_i),
      .state_o(st_m2), .rise_o(ri_m2), .fall_o(fa_m2), .timeout_o(to_m2),
      .any_o(any_m2), .all_o(all_m2), .count_o(cnt_m2));

   sr_flag_bank #(.N_FLAGS(4), .CONFLICT_MODE(3), .EDGE_SET(1), .TIMEOUT_CYCLES(4)) u_mn (
      .clk(clk), .reset_n(reset_n), .set_i(set_i), .rst_i(rst_i),
      .state_o(st_mn), .rise_o(ri_mn), .fall_o(fa_mn), .timeout_o(to_mn),
      .any_o(any_mn), .all_o(all_mn), .count_o(cnt_mn));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       rn;
      logic [3:0] set;
      logic [3:0] rst;
      logic [3:0] e_l3;
      logic [3:0] e_m0;
      logic [3:0] e_m1;
      logic [3:0] e_m2;
      logic [3:0] e_rise;
      logic [3:0] e_fall;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One set pulse on flag 0 of the timeout instance: high for exactly 4 cycles
   task automatic tmo_single(input string tag);
      for (int c = 1; c <= 5; c++) begin
         set_i = (c == 1) ? 4'h1 : 4'h0;
         rst_i = 4'h0;
         step();
         check($sformatf("%s c%0d state", tag, c), 32'(st_mn[0]), 32'(c <= 4));
         check($sformatf("%s c%0d fall", tag, c), 32'(fa_mn[0]), 32'(c == 5));
         check($sformatf("%s c%0d timeout", tag, c), 32'(to_mn[0]), 32'(c == 5));
      end
   endtask

   initial begin
      tbl[0]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[1]  = '{1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
      tbl[2]  = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1};
      tbl[3]  = '{1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
      tbl[4]  = '{1'b1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
      tbl[5]  = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1};
      tbl[6]  = '{1'b1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0};
      tbl[7]  = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
      tbl[8]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[9]  = '{1'b1, 4'hA, 4'h0, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h0};
      tbl[10] = '{1'b1, 4'h6, 4'h3, 4'hC, 4'hE, 4'hE, 4'hC, 4'h4, 4'h2};

      // reset with set held, then release on the edge-set instance
      reset_n = 1'b0;
      set_i   = 4'hF;
      rst_i   = 4'h0;
      for (int c = 0; c < 2; c++) begin
         step();
         check($sformatf("rst%0d state", c), 32'(st_mn), 32'h0);
         check($sformatf("rst%0d rise", c), 32'(ri_mn), 32'h0);
         check($sformatf("rst%0d fall", c), 32'(fa_mn), 32'h0);
         check($sformatf("rst%0d timeout", c), 32'(to_mn), 32'h0);
         check($sformatf("rst%0d count", c), 32'(cnt_mn), 32'h0);
         check($sformatf("rst%0d any", c), 32'(any_mn), 32'h0);
         check($sformatf("rst%0d all", c), 32'(all_mn), 32'h0);
      end
      reset_n = 1'b1;
      step();
      check("release state", 32'(st_mn), 32'hF);
      check("release rise", 32'(ri_mn), 32'hF);
      check("release count", 32'(cnt_mn), 32'd4);
      check("release all", 32'(all_mn), 32'h1);
      step();
      check("held state", 32'(st_mn), 32'hF);
      check("held rise", 32'(ri_mn), 32'h0);

      // conflict-mode vectors
      for (int i = 0; i < 11; i++) begin
         reset_n = tbl[i].rn;
         set_i   = tbl[i].set;
         rst_i   = tbl[i].rst;
         step();
         check($sformatf("v%0d mode3 state", i), 32'(st_l3), 32'(tbl[i].e_l3));
         check($sformatf("v%0d mode0 state", i), 32'(st_m0), 32'(tbl[i].e_m0));
         check($sformatf("v%0d mode1 state", i), 32'(st_m1), 32'(tbl[i].e_m1));
         check($sformatf("v%0d mode2 state", i), 32'(st_m2), 32'(tbl[i].e_m2));
         check($sformatf("v%0d mode3 rise", i), 32'(ri_l3), 32'(tbl[i].e_rise));
         check($sformatf("v%0d mode3 fall", i), 32'(fa_l3), 32'(tbl[i].e_fall));
         check($sformatf("v%0d mode1 count", i), 32'(cnt_m1), 32'($countones(tbl[i].e_m1)));
      end

      // edge-set vs level-set: set held 5 cycles on flag 1, clear in cycle 2
      reset_n = 1'b0;
      set_i   = 4'h0;
      rst_i   = 4'h0;
      step();
      reset_n = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         set_i = 4'h2;
         rst_i = (c == 2) ? 4'h2 : 4'h0;
         step();
         check($sformatf("edge c%0d state", c), 32'(st_mn[1]), 32'(c == 1));
         check($sformatf("level c%0d state", c), 32'(st_l3[1]), 32'(c != 2));
      end
      set_i = 4'h0;
      rst_i = 4'hF;
      step();
      rst_i = 4'h0;
      step();

      // timeout: single pulse, retrigger, explicit clear on the expiry cycle
      tmo_single("tmo");
      for (int c = 1; c <= 8; c++) begin
         set_i = (c == 1 || c == 4) ? 4'h1 : 4'h0;
         rst_i = 4'h0;
         step();
         check($sformatf("retrig c%0d state", c), 32'(st_mn[0]), 32'(c <= 7));
         check($sformatf("retrig c%0d timeout", c), 32'(to_mn[0]), 32'(c == 8));
      end
      for (int c = 1; c <= 5; c++) begin
         set_i = (c == 1) ? 4'h1 : 4'h0;
         rst_i = (c == 5) ? 4'h1 : 4'h0;
         step();
         check($sformatf("clrexp c%0d state", c), 32'(st_mn[0]), 32'(c <= 4));
         check($sformatf("clrexp c%0d fall", c), 32'(fa_mn[0]), 32'(c == 5));
         check($sformatf("clrexp c%0d timeout", c), 32'(to_mn[0]), 32'h0);
      end

      // aggregates: set flags 0..3 on successive cycles, then clear all at once
      // (flag 0 reaches its expiry cycle just as the clear arrives)
      for (int c = 1; c <= 4; c++) begin
         set_i = 4'(1 << (c - 1));
         rst_i = 4'h0;
         step();
         check($sformatf("agg c%0d count", c), 32'(cnt_mn), 32'(c));
         check($sformatf("agg c%0d all", c), 32'(all_mn), 32'(c == 4));
         check($sformatf("agg c%0d any", c), 32'(any_mn), 32'h1);
      end
      set_i = 4'h0;
      rst_i = 4'hF;
      step();
      check("clrall count", 32'(cnt_mn), 32'h0);
      check("clrall any", 32'(any_mn), 32'h0);
      check("clrall fall", 32'(fa_mn), 32'hF);
      check("clrall timeout", 32'(to_mn), 32'h0);
      rst_i = 4'h0;
      step();

      // reset while three flags are mid-timeout
      set_i = 4'h7;
      step();
      set_i = 4'h0;
      step();
      check("pre-reset state", 32'(st_mn), 32'h7);
      reset_n = 1'b0;
      step();
      check("midrst state", 32'(st_mn), 32'h0);
      check("midrst fall", 32'(fa_mn), 32'h0);
      check("midrst timeout", 32'(to_mn), 32'h0);
      check("midrst count", 32'(cnt_mn), 32'h0);
      reset_n = 1'b1;
      step();
      check("post-reset fall", 32'(fa_mn), 32'h0);
      tmo_single("postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
